// File: rtl/fb_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fb_mem_arbiter_pkg
// Shared definitions for the frame-buffer memory arbiter:
//   - default data/address widths
//   - idx_width(): index width for an N-entry set, never less than one bit
//   - src_e: which port owns the single RAM access in a given cycle
// -----------------------------------------------------------------------------
package fb_mem_arbiter_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;

  // A single entry still needs a one-bit index so vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    SrcNone,
    SrcDisp,
    SrcClient
  } src_e;

endpackage

// File: rtl/fb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fb_rr_arbiter
// Round-robin arbiter over NUM_CLIENTS requesters. The search starts one past
// the most recently granted index, so the last winner has lowest priority.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_en            arbitration allowed this cycle (no grant when low)
//   i_req           per-client request vector
//   o_gnt           one-hot grant (combinational)
//   o_idx           index of the granted client (valid when |o_gnt)
// -----------------------------------------------------------------------------
module fb_rr_arbiter
  import fb_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned CIDX_W      = idx_width(NUM_CLIENTS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [NUM_CLIENTS-1:0] i_req,
  output logic [NUM_CLIENTS-1:0] o_gnt,
  output logic [CIDX_W-1:0]      o_idx
);

  logic [CIDX_W-1:0] r_ptr;
  logic [CIDX_W-1:0] w_idx;
  logic              w_found;

  always_comb begin
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      int unsigned cand;
      cand = (32'(r_ptr) + k) % NUM_CLIENTS;
      if (!w_found && i_req[cand]) begin
        w_found = 1'b1;
        w_idx   = CIDX_W'(cand);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (i_en && w_found) begin
      o_gnt[w_idx] = 1'b1;
    end
  end

  assign o_idx = w_idx;

  // Reset pointer to the last client so client 0 wins the first round.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= CIDX_W'(NUM_CLIENTS - 1);
    end else if (i_en && w_found) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fb_mem_arbiter
// Single-port synchronous frame-buffer RAM shared by one display read port
// (strict priority) and NUM_CLIENTS read/write client ports (round-robin).
// A starvation counter forces one client access after STARVE_LIMIT
// consecutive display wins over a pending client.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cl_req/cl_we          per-client request and write enable
//   cl_addr/cl_wdata      packed per-client address and write data
//   cl_gnt                one-hot client grant (access on the ending edge)
//   cl_rdata/cl_rvalid    shared client read data, one-hot valid
//   disp_req/disp_addr    display read request and address
//   disp_gnt              display grant
//   disp_rdata/rvalid     display read data and valid
// Read data appears exactly one cycle after the grant.
// -----------------------------------------------------------------------------
module fb_mem_arbiter
  import fb_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_gnt,
  output logic [DATA_W-1:0]             cl_rdata,
  output logic [NUM_CLIENTS-1:0]        cl_rvalid,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_gnt,
  output logic [DATA_W-1:0]             disp_rdata,
  output logic                          disp_rvalid
);

  localparam int unsigned CIDX_W    = idx_width(NUM_CLIENTS);
  localparam int unsigned RAM_IDX_W = idx_width(DEPTH);
  localparam int unsigned STARVE_W  = $clog2(STARVE_LIMIT + 1);

  logic                   w_any_cl;
  logic                   w_force;
  logic                   w_disp_gnt;
  logic                   w_cl_en;
  logic [NUM_CLIENTS-1:0] w_cl_gnt;
  logic [CIDX_W-1:0]      w_cl_idx;
  logic [STARVE_W-1:0]    r_starve_cnt;

  src_e                   w_src;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_we;
  logic [DATA_W-1:0]      w_wdata;
  logic                   w_in_range;
  logic [RAM_IDX_W-1:0]   w_ram_idx;
  logic [DATA_W-1:0]      w_rd_word;

  logic [DATA_W-1:0]      r_ram [DEPTH];
  logic [NUM_CLIENTS-1:0] r_cl_rvalid;
  logic                   r_disp_rvalid;
  logic [DATA_W-1:0]      r_cl_rdata;
  logic [DATA_W-1:0]      r_disp_rdata;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_any_cl   = |cl_req;
  assign w_force    = (r_starve_cnt == STARVE_W'(STARVE_LIMIT)) && w_any_cl;
  assign w_disp_gnt = !reset && disp_req && !w_force;
  // Clients only compete when the display did not take the slot.
  assign w_cl_en    = !reset && !w_disp_gnt;

  fb_rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .CIDX_W      (CIDX_W)
  ) u_rr_arbiter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_cl_en),
    .i_req   (cl_req),
    .o_gnt   (w_cl_gnt),
    .o_idx   (w_cl_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (|w_cl_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_disp_gnt && w_any_cl && (r_starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Access source select
  // ---------------------------------------------------------------------------
  always_comb begin
    w_src   = SrcNone;
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    if (w_disp_gnt) begin
      w_src  = SrcDisp;
      w_addr = disp_addr;
    end else if (|w_cl_gnt) begin
      w_src   = SrcClient;
      w_addr  = cl_addr[32'(w_cl_idx) * ADDR_W +: ADDR_W];
      w_we    = cl_we[w_cl_idx];
      w_wdata = cl_wdata[32'(w_cl_idx) * DATA_W +: DATA_W];
    end
  end

  // Out-of-range addresses still consume the slot but never touch the RAM.
  assign w_in_range = (64'(w_addr) < 64'(DEPTH));
  assign w_ram_idx  = w_addr[RAM_IDX_W-1:0];
  assign w_rd_word  = w_in_range ? r_ram[w_ram_idx] : '0;

  // ---------------------------------------------------------------------------
  // RAM (contents survive reset; grants are already blocked during reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((w_src == SrcClient) && w_we && w_in_range) begin
      r_ram[w_ram_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cl_rvalid   <= '0;
      r_disp_rvalid <= 1'b0;
      r_cl_rdata    <= '0;
      r_disp_rdata  <= '0;
    end else begin
      r_cl_rvalid   <= '0;
      r_disp_rvalid <= 1'b0;
      unique case (w_src)
        SrcDisp: begin
          r_disp_rvalid <= 1'b1;
          r_disp_rdata  <= w_rd_word;
        end
        SrcClient: begin
          if (!w_we) begin
            r_cl_rvalid <= w_cl_gnt;
            r_cl_rdata  <= w_rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; a reset in the cycle after a grant hides the pending rvalid.
  // ---------------------------------------------------------------------------
  assign cl_gnt      = w_cl_gnt;
  assign disp_gnt    = w_disp_gnt;
  assign cl_rdata    = r_cl_rdata;
  assign disp_rdata  = r_disp_rdata;
  assign cl_rvalid   = reset ? '0 : r_cl_rvalid;
  assign disp_rvalid = !reset && r_disp_rvalid;

endmodule
